// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive framer.
// Holds the framer state encoding plus the framing and CRC constants.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_RECEIVE  = 2'd2,
    ST_DROP     = 2'd3
  } framer_state_e;

  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_HDR_BYTES   = 14;
  localparam int          ETH_FCS_BYTES   = 4;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 accumulator (no final XOR), preset to all ones.
// i_init has priority over i_en so the framer can hold it preset between frames.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_crc <= '1;
    end else if (i_init) begin
      o_crc <= '1;
    end else if (i_en) begin
      o_crc <= crc32_byte(o_crc, i_data);
    end
  end

endmodule

// File: rtl/ethernet_rx_framer.sv
// Serial-bit Ethernet receive framer: SFD hunt, byte assembly, header extraction,
// payload streaming with FCS stripped via a 5-byte delay line, end-of-frame status.
//
// state    | meaning
// IDLE     | waiting for carrier
// PREAMBLE | hunting for SFD after enough preamble bits
// RECEIVE  | assembling bytes, loading header, streaming payload
// DROP     | frame too long, discarding until carrier drops
module ethernet_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_PREAMBLE_BITS = 16,
  parameter int MIN_FRAME_BYTES   = 64,
  parameter int MAX_FRAME_BYTES   = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bit,
  input  logic        i_bit_valid,
  input  logic        i_carrier,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic        o_hdr_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_data_last,
  output logic        o_frame_done,
  output logic        o_fcs_ok,
  output logic        o_err_runt,
  output logic        o_err_oversize,
  output logic        o_err_align
);

  localparam int              PCW       = $clog2(MIN_PREAMBLE_BITS + 2);
  localparam logic [PCW-1:0]  PRE_SAT   = PCW'(MIN_PREAMBLE_BITS);
  localparam logic [10:0]     MIN_B     = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]     MAX_B     = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0]     HDR_B     = 11'(ETH_HDR_BYTES);
  localparam int              DLY_DEPTH = ETH_FCS_BYTES + 1;
  localparam logic [2:0]      DLY_FULL  = 3'(DLY_DEPTH);

  framer_state_e state, state_nxt;

  logic [6:0]     pre_sr;
  logic [7:0]     pre_sr_nxt;
  logic [PCW-1:0] pre_cnt, pre_cnt_inc;
  logic [6:0]     byte_sr;
  logic [7:0]     byte_in;
  logic [2:0]     bit_cnt;
  logic [10:0]    byte_cnt;
  logic [DLY_DEPTH-1:0][7:0] dly;
  logic [2:0]     dly_cnt;
  logic [31:0]    crc;

  logic bit_take, sfd_hit, byte_done, byte_ovf, dly_full, eof_rx, eof_drop;

  always_comb begin
    bit_take    = i_carrier && i_bit_valid;
    pre_sr_nxt  = {i_bit, pre_sr};
    pre_cnt_inc = (pre_cnt == PRE_SAT) ? pre_cnt : pre_cnt + 1'b1;
    byte_in     = {i_bit, byte_sr};
    sfd_hit     = (state == ST_PREAMBLE) && bit_take &&
                  (pre_sr_nxt == ETH_SFD) && (pre_cnt_inc >= PRE_SAT);
    byte_done   = (state == ST_RECEIVE) && bit_take && (bit_cnt == 3'd7);
    byte_ovf    = byte_done && (byte_cnt == MAX_B);
    dly_full    = (dly_cnt == DLY_FULL);
    eof_rx      = (state == ST_RECEIVE) && !i_carrier;
    eof_drop    = (state == ST_DROP) && !i_carrier;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (i_carrier) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (!i_carrier) state_nxt = ST_IDLE;
                   else if (sfd_hit) state_nxt = ST_RECEIVE;
      ST_RECEIVE:  if (!i_carrier) state_nxt = ST_IDLE;
                   else if (byte_ovf) state_nxt = ST_DROP;
      ST_DROP:     if (!i_carrier) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  eth_crc32 u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (state != ST_RECEIVE),
    .i_en    (byte_done),
    .i_data  (byte_in),
    .o_crc   (crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_sr         <= '0;
      pre_cnt        <= '0;
      byte_sr        <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      dly            <= '0;
      dly_cnt        <= '0;
      o_dst_mac      <= '0;
      o_src_mac      <= '0;
      o_ethertype    <= '0;
      o_hdr_valid    <= 1'b0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_data_last    <= 1'b0;
      o_frame_done   <= 1'b0;
      o_fcs_ok       <= 1'b0;
      o_err_runt     <= 1'b0;
      o_err_oversize <= 1'b0;
      o_err_align    <= 1'b0;
    end else begin
      o_hdr_valid  <= 1'b0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_frame_done <= 1'b0;

      if (state != ST_PREAMBLE) begin
        pre_sr  <= '0;
        pre_cnt <= '0;
      end else if (bit_take) begin
        pre_sr  <= pre_sr_nxt[7:1];
        pre_cnt <= pre_cnt_inc;
      end

      if (state != ST_RECEIVE) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        dly_cnt  <= '0;
      end else if (bit_take) begin
        byte_sr <= byte_in[7:1];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          byte_cnt <= byte_cnt + 11'd1;
          if (byte_cnt < 11'd6)       o_dst_mac   <= {o_dst_mac[39:0], byte_in};
          else if (byte_cnt < 11'd12) o_src_mac   <= {o_src_mac[39:0], byte_in};
          else if (byte_cnt < HDR_B)  o_ethertype <= {o_ethertype[7:0], byte_in};
          if (byte_cnt == HDR_B - 11'd1) o_hdr_valid <= 1'b1;
          // The byte that overflows still releases the entry five behind it.
          if (byte_cnt >= HDR_B) begin
            dly <= {dly[DLY_DEPTH-2:0], byte_in};
            if (dly_full) begin
              o_data       <= dly[DLY_DEPTH-1];
              o_data_valid <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + 3'd1;
            end
          end
        end
      end

      if (eof_rx) begin
        o_frame_done   <= 1'b1;
        o_fcs_ok       <= (crc == ETH_CRC_RESIDUE);
        o_err_runt     <= !dly_full || (byte_cnt < MIN_B);
        o_err_oversize <= 1'b0;
        o_err_align    <= (bit_cnt != 3'd0);
        if (dly_full) begin
          o_data       <= dly[DLY_DEPTH-1];
          o_data_valid <= 1'b1;
          o_data_last  <= 1'b1;
        end
      end

      if (eof_drop) begin
        o_frame_done   <= 1'b1;
        o_fcs_ok       <= 1'b0;
        o_err_runt     <= 1'b0;
        o_err_oversize <= 1'b1;
        o_err_align    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_rx_framer.sv
// Directed bench for ethernet_rx_framer: frames are built and CRC'd here, expected
// header/data/status are queued as each frame is sent and popped as the DUT emits.
module tb_ethernet_rx_framer;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_bit = 1'b0;
  logic i_bit_valid = 1'b0;
  logic i_carrier = 1'b0;
  logic [47:0] o_dst_mac, o_src_mac;
  logic [15:0] o_ethertype;
  logic        o_hdr_valid, o_data_valid, o_data_last, o_frame_done;
  logic [7:0]  o_data;
  logic        o_fcs_ok, o_err_runt, o_err_oversize, o_err_align;

  int checks = 0;
  int failures = 0;
  bit gaps_en = 1'b0;

  logic [7:0]   fr[$];
  logic [111:0] exp_hdr[$];
  logic [8:0]   exp_data[$];
  logic [3:0]   exp_stat[$];

  always #5 i_clk = ~i_clk;

  ethernet_rx_framer #(
    .MIN_PREAMBLE_BITS(16),
    .MIN_FRAME_BYTES  (MIN_FRAME),
    .MAX_FRAME_BYTES  (MAX_FRAME)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .i_carrier(i_carrier), .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
    .o_ethertype(o_ethertype), .o_hdr_valid(o_hdr_valid), .o_data(o_data),
    .o_data_valid(o_data_valid), .o_data_last(o_data_last), .o_frame_done(o_frame_done),
    .o_fcs_ok(o_fcs_ok), .o_err_runt(o_err_runt), .o_err_oversize(o_err_oversize),
    .o_err_align(o_err_align)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (o_hdr_valid) begin
      if (exp_hdr.size() == 0) check("hdr_unexpected", 128'(o_hdr_valid), 128'd0);
      else check("hdr_fields", 128'({o_dst_mac, o_src_mac, o_ethertype}), 128'(exp_hdr.pop_front()));
    end
    if (o_data_valid) begin
      if (exp_data.size() == 0) check("data_unexpected", 128'(o_data_valid), 128'd0);
      else check("data_beat", 128'({o_data_last, o_data}), 128'(exp_data.pop_front()));
    end
    if (o_frame_done) begin
      if (exp_stat.size() == 0) check("done_unexpected", 128'(o_frame_done), 128'd0);
      else check("frame_status", 128'({o_fcs_ok, o_err_runt, o_err_oversize, o_err_align}),
                 128'(exp_stat.pop_front()));
    end
  endtask

  // Inputs change at the negedge; outputs are checked at the following negedge.
  task automatic step(input logic b, input logic bv, input logic car);
    i_bit = b;
    i_bit_valid = bv;
    i_carrier = car;
    @(posedge i_clk);
    @(negedge i_clk);
    monitor();
  endtask

  task automatic send_bit(input logic b);
    if (gaps_en) repeat ($urandom_range(0, 2)) step(1'($urandom), 1'b0, 1'b1);
    step(b, 1'b1, 1'b1);
  endtask

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ fr[i][k];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic build_frame(input int plen);
    logic [31:0] fcs;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'(i + 1));
    for (int i = 0; i < 6; i++) fr.push_back(8'(i + 10));
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int i = 0; i < plen; i++) fr.push_back(8'(i));
    fcs = ~crc_of(fr.size());
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic fcs_ok, input logic align);
    int len;
    logic [111:0] h;
    len = fr.size();
    h = '0;
    if (len >= 14) begin
      for (int i = 0; i < 14; i++) h = {h[103:0], fr[i]};
      exp_hdr.push_back(h);
    end
    if (len > MAX_FRAME) begin
      // Byte MAX_FRAME+1 still releases its FIFO entry, giving MAX_FRAME-18 beats.
      for (int i = 14; i < MAX_FRAME - 4; i++) exp_data.push_back({1'b0, fr[i]});
      exp_stat.push_back(4'b0010);
    end else begin
      if (len >= 19)
        for (int i = 14; i < len - 4; i++) exp_data.push_back({1'(i == len - 5), fr[i]});
      exp_stat.push_back({fcs_ok, 1'((len < MIN_FRAME) || (len < 19)), 1'b0, align});
    end
  endtask

  task automatic send_frame(input int extra_bits, input int abort_byte);
    logic [7:0] b;
    b = 8'hD5;
    for (int i = 0; i < 56; i++) send_bit(1'((i % 2) == 0));
    for (int k = 0; k < 8; k++) send_bit(b[k]);
    for (int n = 0; n < fr.size(); n++) begin
      if (n == abort_byte) begin
        i_rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("rst_mid_dst", 128'(o_dst_mac), 128'd0);
        step(1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        break;
      end
      b = fr[n];
      for (int k = 0; k < 8; k++) send_bit(b[k]);
    end
    for (int k = 0; k < extra_bits; k++) send_bit(1'(k % 2));
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("hdr_pending",  128'(exp_hdr.size()),  128'd0);
    check("data_pending", 128'(exp_data.size()), 128'd0);
    check("done_pending", 128'(exp_stat.size()), 128'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("reset_outputs", 128'({o_dst_mac, o_src_mac, o_ethertype, o_hdr_valid, o_data,
          o_data_valid, o_data_last, o_frame_done, o_fcs_ok, o_err_runt, o_err_oversize,
          o_err_align}), 128'd0);
    i_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    build_frame(46);
    check("hdr_model", 128'({fr[0], fr[5], fr[6], fr[11], fr[12], fr[13]}), 128'h01060A0F0800);
    expect_frame(1'b1, 1'b0);
    send_frame(0, -1);

    build_frame(46);
    fr[20] = fr[20] ^ 8'h04;
    expect_frame(1'b0, 1'b0);
    send_frame(0, -1);

    build_frame(20);
    expect_frame(1'b1, 1'b0);
    send_frame(0, -1);

    build_frame(46);
    while (fr.size() > 10) void'(fr.pop_back());
    expect_frame(1'b0, 1'b0);
    send_frame(0, -1);

    gaps_en = 1'b1;
    build_frame(46);
    expect_frame(1'b1, 1'b1);
    send_frame(3, -1);
    gaps_en = 1'b0;

    build_frame(1501);
    expect_frame(1'b0, 1'b0);
    send_frame(0, -1);

    build_frame(46);
    send_frame(0, 8);
    build_frame(46);
    expect_frame(1'b1, 1'b0);
    send_frame(0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ethernet_rx_framer.md
Name: ethernet_rx_framer

Overview:
- Downstream consumer of the single-ended Ethernet bit receiver; takes the recovered serial bit stream plus carrier indication and turns it into frames.
- Detects preamble/SFD, assembles LSB-first bytes, and extracts destination MAC, source MAC and ethertype.
- Streams the payload bytes with the 4-byte FCS stripped, and reports FCS/length/alignment status at end of frame.
- Its outputs feed the MAC-filter and ethertype-dispatch logic.

Parameters:
- MIN_PREAMBLE_BITS, 16: minimum received preamble+SFD bits before the SFD is accepted.
- MIN_FRAME_BYTES, 64: minimum frame length, DST through FCS inclusive; shorter frames flag runt.
- MAX_FRAME_BYTES, 1518: maximum frame length, DST through FCS inclusive; longer frames flag oversize.

Ports:
- i_clk  in  1  block clock; all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bit  in  1  received serial bit, LSB of each byte first.
- i_bit_valid  in  1  i_bit is valid this cycle; one bit per asserted cycle.
- i_carrier  in  1  high while a frame is on the wire; falling edge marks end of frame.
- o_dst_mac  out  48  destination MAC; first byte on wire in [47:40].
- o_src_mac  out  48  source MAC, same byte order.
- o_ethertype  out  16  ethertype; first byte on wire in [15:8].
- o_hdr_valid  out  1  one-cycle pulse when the three header fields are updated.
- o_data  out  8  payload byte.
- o_data_valid  out  1  o_data valid this cycle.
- o_data_last  out  1  qualifies o_data_valid; last payload byte.
- o_frame_done  out  1  one-cycle pulse; all status outputs valid this cycle.
- o_fcs_ok  out  1  CRC residue check passed.
- o_err_runt  out  1  frame shorter than MIN_FRAME_BYTES.
- o_err_oversize  out  1  frame exceeded MAX_FRAME_BYTES.
- o_err_align  out  1  bit count after SFD not a multiple of 8.

Behaviour:
- Reset: every output is 0, state is IDLE, the delay buffer is empty, and CRC = 32'hFFFFFFFF.
- Reset is honoured mid-frame: the frame is discarded and no o_frame_done is issued.
- States: IDLE, PREAMBLE, RECEIVE, DROP.
- IDLE -> PREAMBLE: when i_carrier is high.
- PREAMBLE:
  - Each valid bit shifts into an 8-bit register at bit7, shifting right, and a saturating preamble bit counter increments.
  - When register == 8'hD5 and counter >= MIN_PREAMBLE_BITS, go to RECEIVE with the byte bit-counter cleared.
  - If the carrier drops in PREAMBLE, return to IDLE silently with no o_frame_done.
- RECEIVE, byte assembly:
  - Bits assemble LSB-first; a byte completes on every 8th valid bit.
  - On completion the byte goes to the CRC (reflected poly 32'hEDB88320, byte-at-a-time, no final XOR), and the 11-bit byte count increments.
- RECEIVE, header:
  - Bytes 0-5 load o_dst_mac, bytes 6-11 load o_src_mac, bytes 12-13 load o_ethertype.
  - o_hdr_valid pulses the cycle after byte 13 completes.
- RECEIVE, payload and FCS stripping:
  - Bytes from 14 onward enter a 5-entry delay FIFO.
  - When a byte arrives and the FIFO already holds 5, the oldest is emitted on o_data with o_data_valid one cycle later.
  - Payload byte i therefore appears one cycle after post-header byte i+5 completes.
- RECEIVE, end of frame (i_carrier low):
  - Next cycle, if the FIFO holds 5 entries, its oldest is emitted with o_data_last=1; the other 4 (FCS) are discarded.
  - o_frame_done pulses in that same cycle, with status:
    - o_fcs_ok = (CRC == 32'hDEBB20E3);
    - o_err_runt = byte count < MIN_FRAME_BYTES;
    - o_err_align = partial bits != 0;
    - o_err_oversize = 0.
  - Status outputs hold until the next o_frame_done or reset.
  - If the FIFO holds fewer than 5 entries, no last byte is emitted, but o_frame_done still pulses with o_err_runt=1. This covers frames ending in the header too.
  - Then return to IDLE.
- Oversize: when the byte count would exceed MAX_FRAME_BYTES, stop emitting and enter DROP. Bytes already emitted are not retracted and no last is emitted.
- DROP: on carrier low, pulse o_frame_done with o_err_oversize=1 and o_fcs_ok=0, then go to IDLE.
- Bit gaps: i_bit_valid low in any state holds all counters and the shift register; no timeout.
- Simultaneity: a bit with i_bit_valid high in the cycle i_carrier falls is ignored.
- Back-to-back frames: the carrier may rise the cycle after o_frame_done; IDLE accepts it immediately.

Decomposition:
- Package eth_pkg: the framer state enum, ETH_SFD=8'hD5, ETH_CRC_POLY=32'hEDB88320, ETH_CRC_RESIDUE=32'hDEBB20E3, ETH_HDR_BYTES=14, ETH_FCS_BYTES=4.
- One sub-module, eth_crc32: combinational byte-wide next-CRC function plus a registered accumulator with init and enable inputs.

Test Plan:
- 56 preamble bits, SFD 0xD5, header DST 01:02:03:04:05:06, SRC 0A:0B:0C:0D:0E:0F, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS, carrier drop:
  - o_hdr_valid fields match exactly;
  - 46 data beats 0x00..0x2D with last on 0x2D;
  - o_frame_done with fcs_ok=1 and all errors 0.
- Same frame with one payload bit flipped -> identical data stream, but o_fcs_ok=0.
- Frame with 20 payload bytes (total 38) -> 20 data beats, o_err_runt=1.
- 1519-byte frame -> 1500 data beats with no last, then o_frame_done with o_err_oversize=1.
- Valid frame with 3 extra bits before carrier drop -> o_err_align=1; random i_bit_valid gaps leave the data stream unchanged.
- Assert i_rst_n low at header byte 8, then send a valid frame -> no o_frame_done for the aborted frame; second frame is received cleanly with fcs_ok=1.
